// File: rtl/fft_r2_stage_sequencer_if.sv
// Handshake and address bus between the FFT stage sequencer and its
// data RAM, twiddle ROM and pipelined butterfly.
interface fft_r2_stage_sequencer_if #(
    parameter int LOG2N = 4
);
    localparam int SW = $clog2(LOG2N);

    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_enable;
    logic             bf_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [SW-1:0]    stage;
    logic             err;

    modport master (
        input  start, bf_valid,
        output busy, done, rd_en, rd_addr_a, rd_addr_b,
        output tw_addr, bf_enable, wr_en, wr_addr_a,
        output wr_addr_b, stage, err
    );

    modport slave (
        output start, bf_valid,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b,
        input  tw_addr, bf_enable, wr_en, wr_addr_a,
        input  wr_addr_b, stage, err
    );
endinterface

// File: rtl/fft_r2_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: walks all stages, issues operand
// and twiddle addresses, and replays them as write-back addresses.
module fft_r2_stage_sequencer #(
    parameter int LOG2N   = 4,
    parameter int RAM_LAT = 1,
    parameter int BF_LAT  = 11
) (
    input logic clk,
    input logic rst_n,
    fft_r2_stage_sequencer_if.master bus
);
    localparam int PIPE = RAM_LAT + BF_LAT;
    localparam int SW   = $clog2(LOG2N);
    localparam int CW   = $clog2(PIPE + 1);
    localparam int KW   = LOG2N - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [SW-1:0]    s;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic             err;
    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;
    logic [KW-1:0]    tw;
    logic [PIPE-1:0]  pipe_en;
    logic [LOG2N-1:0] pipe_a [PIPE];
    logic [LOG2N-1:0] pipe_b [PIPE];
    logic             wr_en;

    function automatic logic [LOG2N-1:0] half_of(
        input logic [SW-1:0] st
    );
        return LOG2N'(1) << st;
    endfunction

    function automatic logic [LOG2N-1:0] j_of(
        input logic [SW-1:0] st,
        input logic [KW-1:0] kk
    );
        return LOG2N'(kk) & (half_of(st) - 1'b1);
    endfunction

    // group*2*half is the group index shifted up by s+1
    function automatic logic [LOG2N-1:0] addr_a(
        input logic [SW-1:0] st,
        input logic [KW-1:0] kk
    );
        logic [LOG2N-1:0] grp;
        grp = LOG2N'(kk) >> st;
        return ((grp << st) << 1) | j_of(st, kk);
    endfunction

    function automatic logic [LOG2N-1:0] addr_b(
        input logic [SW-1:0] st,
        input logic [KW-1:0] kk
    );
        return addr_a(st, kk) + half_of(st);
    endfunction

    function automatic logic [KW-1:0] tw_of(
        input logic [SW-1:0] st,
        input logic [KW-1:0] kk
    );
        return KW'(j_of(st, kk) << (KW - int'(st)));
    endfunction

    assign wr_en = pipe_en[PIPE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
            err   <= 1'b0;
            rd_a  <= '0;
            rd_b  <= '0;
            tw    <= '0;
        end else begin
            done <= 1'b0;
            if (busy && (bus.bf_valid != wr_en)) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ISSUE;
                        s     <= '0;
                        k     <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        rd_a  <= addr_a('0, '0);
                        rd_b  <= addr_b('0, '0);
                        tw    <= tw_of('0, '0);
                    end
                end
                ISSUE: begin
                    if (&k) begin
                        state <= DRAIN;
                        cnt   <= CW'(PIPE - 1);
                        rd_en <= 1'b0;
                        rd_a  <= '0;
                        rd_b  <= '0;
                        tw    <= '0;
                    end else begin
                        k    <= k + 1'b1;
                        rd_a <= addr_a(s, k + 1'b1);
                        rd_b <= addr_b(s, k + 1'b1);
                        tw   <= tw_of(s, k + 1'b1);
                    end
                end
                DRAIN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (s == SW'(LOG2N - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ISSUE;
                        s     <= s + 1'b1;
                        k     <= '0;
                        rd_en <= 1'b1;
                        rd_a  <= addr_a(s + 1'b1, '0);
                        rd_b  <= addr_b(s + 1'b1, '0);
                        tw    <= tw_of(s + 1'b1, '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running so write-backs of the last stage drain during DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_en <= '0;
            for (int i = 0; i < PIPE; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_en   <= (pipe_en << 1) | PIPE'(rd_en);
            pipe_a[0] <= rd_a;
            pipe_b[0] <= rd_b;
            for (int i = 1; i < PIPE; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.bf_enable = busy;
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_addr   = tw;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr_a = pipe_a[PIPE-1];
    assign bus.wr_addr_b = pipe_b[PIPE-1];
    assign bus.stage     = s;
    assign bus.err       = err;
endmodule

// File: tb/tb_fft_r2_stage_sequencer.sv
// Scoreboard bench for the FFT stage sequencer: a reference model
// queues expected reads, writes and done pulses; a monitor pops them.
module tb_fft_r2_stage_sequencer;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int PIPE  = 12;
    localparam int P     = N / 2 + PIPE;
    localparam int RUN   = LOG2N * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic glitch = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r2_stage_sequencer_if #(.LOG2N(4)) bus ();
    fft_r2_stage_sequencer_if #(.LOG2N(2)) bus2 ();

    assign bus.bf_valid  = bus.wr_en & ~glitch;
    assign bus2.bf_valid = bus2.wr_en;

    fft_r2_stage_sequencer #(
        .LOG2N(4), .RAM_LAT(1), .BF_LAT(11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    fft_r2_stage_sequencer #(
        .LOG2N(2), .RAM_LAT(1), .BF_LAT(11)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        int t;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    typedef struct {
        int t;
        int e;
    } dn_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    dn_t done_q[$];
    int  checks = 0;
    int  errors = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  idle_from = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic bf_addr(input int n, input int s, input int k,
                           output int a, output int b, output int tw);
        int half;
        half = 1 << s;
        a  = (k / half) * 2 * half + (k % half);
        b  = a + half;
        tw = (k % half) * (n / (2 * half));
    endtask

    // t0 is the cycle in which start is high
    task automatic model_run(input int t0);
        ev_t e;
        dn_t d;
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                bf_addr(N, s, k, e.a, e.b, e.tw);
                e.st = s;
                e.t  = t0 + 1 + s * P + k;
                rd_q.push_back(e);
                e.t = e.t + PIPE;
                wr_q.push_back(e);
            end
        end
        d.t = t0 + RUN + 1;
        d.e = 0;
        done_q.push_back(d);
        busy_lo   = t0 + 1;
        busy_hi   = t0 + RUN;
        idle_from = t0 + RUN + 1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // called at a negedge; returns the accepted start cycle or -1
    task automatic pulse_start(output int t0);
        int c;
        c = cyc;
        t0 = -1;
        bus.start = 1'b1;
        if (c >= idle_from) begin
            model_run(c);
            t0 = c;
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (t0 >= 0) chk("err_clear", int'(bus.err), 0);
    endtask

    function automatic int outs1();
        return int'({bus.busy, bus.done, bus.rd_en,
                     bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                     bus.bf_enable, bus.wr_en, bus.wr_addr_a,
                     bus.wr_addr_b, bus.stage, bus.err});
    endfunction

    function automatic int outs2();
        return int'({bus2.busy, bus2.done, bus2.rd_en,
                     bus2.rd_addr_a, bus2.rd_addr_b, bus2.tw_addr,
                     bus2.bf_enable, bus2.wr_en, bus2.wr_addr_a,
                     bus2.wr_addr_b, bus2.stage, bus2.err});
    endfunction

    always @(negedge clk) begin : mon
        ev_t r;
        dn_t d;
        int  exp_busy;
        if (rst_n) begin
            if (bus.rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_cycle", cyc, r.t);
                    chk("rd_addr_a", int'(bus.rd_addr_a), r.a);
                    chk("rd_addr_b", int'(bus.rd_addr_b), r.b);
                    chk("tw_addr", int'(bus.tw_addr), r.tw);
                    chk("stage", int'(bus.stage), r.st);
                end
            end
            if (bus.wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    r = wr_q.pop_front();
                    chk("wr_cycle", cyc, r.t);
                    chk("wr_addr_a", int'(bus.wr_addr_a), r.a);
                    chk("wr_addr_b", int'(bus.wr_addr_b), r.b);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.t);
                    chk("err_at_done", int'(bus.err), d.e);
                end
            end
            exp_busy = int'(cyc >= busy_lo && cyc <= busy_hi);
            chk("busy", int'(bus.busy), exp_busy);
            chk("bf_enable", int'(bus.bf_enable), exp_busy);
        end
    end

    initial begin : stim
        int t0;
        int tn;
        int n2;
        int got_done;
        int a, b, tw;
        dn_t d;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        #2;
        chk("reset_outs", outs1(), 0);
        chk("reset_outs2", outs2(), 0);
        #20;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // run A with ignored starts in cycles 5 and 40
        pulse_start(t0);
        wait_cyc(t0 + 5);
        pulse_start(tn);
        wait_cyc(t0 + 40);
        pulse_start(tn);
        wait_cyc(t0 + RUN);
        pulse_start(tn);
        chk("start_before_done_ignored", tn, -1);

        // run B starts in the done cycle of run A
        wait_cyc(t0 + RUN + 1);
        pulse_start(t0);
        chk("start_in_done_accepted", int'(t0 >= 0), 1);
        wait_cyc(t0 + 13);
        glitch = 1'b1;
        d = done_q.pop_back();
        d.e = 1;
        done_q.push_back(d);
        @(negedge clk);
        glitch = 1'b0;
        chk("err_set", int'(bus.err), 1);
        wait_cyc(t0 + RUN + 1 + $urandom_range(1, 5));

        // run C aborted by reset in cycle 30
        pulse_start(t0);
        wait_cyc(t0 + 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs1(), 0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_lo   = 1;
        busy_hi   = 0;
        idle_from = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_reset_quiet",
                int'(bus.wr_en) + int'(bus.done), 0);
        end

        // randomized runs with random ignored starts
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            pulse_start(t0);
            wait_cyc(t0 + $urandom_range(2, 40));
            pulse_start(tn);
            wait_cyc(t0 + $urandom_range(41, RUN));
            pulse_start(tn);
            wait_cyc(t0 + RUN + 1);
        end
        wait_cyc(cyc + 5);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        // LOG2N=2 instance: 2 stages of 2 butterflies
        n2 = 0;
        got_done = 0;
        t0 = cyc;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus2.rd_en) begin
                bf_addr(4, n2 / 2, n2 % 2, a, b, tw);
                chk("n4_rd_cycle", cyc,
                    t0 + 1 + (n2 / 2) * 14 + (n2 % 2));
                chk("n4_rd_addr_a", int'(bus2.rd_addr_a), a);
                chk("n4_rd_addr_b", int'(bus2.rd_addr_b), b);
                chk("n4_tw_addr", int'(bus2.tw_addr), tw);
                n2++;
            end
            if (bus2.done) begin
                chk("n4_done_cycle", cyc, t0 + 29);
                got_done++;
            end
            @(negedge clk);
        end
        chk("n4_reads", n2, 4);
        chk("n4_done_seen", got_done, 1);
        chk("n4_err", int'(bus2.err), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
